mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp.sv | 150 +++++++++++++++
 tb/tb_mem_resp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp.sv
// Single-ported memory responder shared by instruction fetch and data access.
// One transaction at a time: grant in IDLE, wait LAT cycles in BUSY, one RESP cycle.
module mem_resp #(
    parameter int unsigned LAT        = 1,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_rd_en_i,
    input  logic [63:0] pc_i,
    output logic [31:0] instr_o,
    output logic        stall_if_o,
    input  logic        mem_rd_en_i,
    input  logic [63:0] addr_mem_rd_i,
    output logic [63:0] data_mem_o,
    input  logic        mem_wr_en_i,
    input  logic [63:0] addr_mem_wr_i,
    input  logic [63:0] data_mem_wr_i,
    input  logic [7:0]  strb_mem_wr_i,
    output logic        stall_mem_o
);

    localparam int unsigned Words    = 1 << DEPTH_LOG2;
    localparam logic        SrvData  = 1'b0;
    localparam logic        SrvInstr = 1'b1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    srv_q, srv_d;
    logic                    lg_q, lg_d;
    logic                    op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    pc2_q, pc2_d;
    logic [63:0]             wdata_q, wdata_d;
    logic [7:0]              strb_q, strb_d;
    logic [63:0]             data_q;
    logic [31:0]             instr_q;
    logic                    data_req;
    logic                    grant_data;
    logic                    access;

    logic [63:0] mem [Words];

    assign data_req = mem_rd_en_i | mem_wr_en_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        srv_d      = srv_q;
        lg_d       = lg_q;
        op_wr_d    = op_wr_q;
        idx_d      = idx_q;
        pc2_d      = pc2_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        grant_data = 1'b0;
        access     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_req || instr_rd_en_i) begin
                    // Contention goes to whichever port lost the previous grant.
                    grant_data = data_req && (!instr_rd_en_i || lg_q == SrvInstr);
                    state_d    = StBusy;
                    cnt_d      = 4'(LAT - 1);
                    if (grant_data) begin
                        srv_d   = SrvData;
                        lg_d    = SrvData;
                        op_wr_d = mem_wr_en_i;
                        idx_d   = mem_wr_en_i ? addr_mem_wr_i[DEPTH_LOG2+2:3]
                                              : addr_mem_rd_i[DEPTH_LOG2+2:3];
                        wdata_d = data_mem_wr_i;
                        strb_d  = strb_mem_wr_i;
                    end else begin
                        srv_d   = SrvInstr;
                        lg_d    = SrvInstr;
                        op_wr_d = 1'b0;
                        idx_d   = pc_i[DEPTH_LOG2+2:3];
                        pc2_d   = pc_i[2];
                    end
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            srv_q   <= SrvData;
            lg_q    <= SrvData;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            pc2_q   <= 1'b0;
            wdata_q <= 64'd0;
            strb_q  <= 8'd0;
            data_q  <= 64'd0;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            srv_q   <= srv_d;
            lg_q    <= lg_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            pc2_q   <= pc2_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            if (access && srv_q == SrvData && !op_wr_q) begin
                data_q <= mem[idx_q];
            end
            if (access && srv_q == SrvInstr) begin
                instr_q <= pc2_q ? mem[idx_q][63:32] : mem[idx_q][31:0];
            end
        end
    end

    // Store is not reset; a reset landing on the access cycle drops the write.
    always_ff @(posedge clk) begin
        if (!rst && access && srv_q == SrvData && op_wr_q) begin
            for (int k = 0; k < 8; k++) begin
                if (strb_q[k]) begin
                    mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign data_mem_o  = data_q;
    assign instr_o     = instr_q;
    assign stall_mem_o = data_req & ~(state_q == StResp && srv_q == SrvData);
    assign stall_if_o  = instr_rd_en_i & ~(state_q == StResp && srv_q == SrvInstr);

    logic unused_bits;
    assign unused_bits = ^{pc_i[63:DEPTH_LOG2+3], pc_i[1:0],
                           addr_mem_rd_i[63:DEPTH_LOG2+3], addr_mem_rd_i[2:0],
                           addr_mem_wr_i[63:DEPTH_LOG2+3], addr_mem_wr_i[2:0]};

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: LAT=1 instance for function, LAT=4 instance for reset abort.
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic        instr_rd_en = 1'b0;
    logic [63:0] pc = 64'd0;
    logic        mem_rd_en = 1'b0;
    logic [63:0] addr_rd = 64'd0;
    logic        mem_wr_en = 1'b0;
    logic [63:0] addr_wr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic [7:0]  strb = 8'd0;

    logic [31:0] instr1, instr4;
    logic [63:0] data1, data4;
    logic        stall_if1, stall_if4, stall_mem1, stall_mem4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_resp #(.LAT(1), .DEPTH_LOG2(12)) u_dut (
        .clk(clk), .rst(rst),
        .instr_rd_en_i(instr_rd_en), .pc_i(pc), .instr_o(instr1), .stall_if_o(stall_if1),
        .mem_rd_en_i(mem_rd_en), .addr_mem_rd_i(addr_rd), .data_mem_o(data1),
        .mem_wr_en_i(mem_wr_en), .addr_mem_wr_i(addr_wr), .data_mem_wr_i(wdata),
        .strb_mem_wr_i(strb), .stall_mem_o(stall_mem1)
    );

    mem_resp #(.LAT(4), .DEPTH_LOG2(12)) u_dut4 (
        .clk(clk), .rst(rst4),
        .instr_rd_en_i(instr_rd_en), .pc_i(pc), .instr_o(instr4), .stall_if_o(stall_if4),
        .mem_rd_en_i(mem_rd_en), .addr_mem_rd_i(addr_rd), .data_mem_o(data4),
        .mem_wr_en_i(mem_wr_en), .addr_mem_wr_i(addr_wr), .data_mem_wr_i(wdata),
        .strb_mem_wr_i(strb), .stall_mem_o(stall_mem4)
    );

    // kind: 0 read, 1 write, 2 fetch. sel: 0 LAT=1 instance, 1 LAT=4 instance.
    // cycles = stall-high cycles (-1 on timeout); rdata sampled in the RESP cycle.
    task automatic do_access(input int sel, input int kind, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [7:0] st,
                             output int cycles, output logic [63:0] rdata);
        logic stall;
        bit   done;
        @(posedge clk); #1;
        case (kind)
            0: begin mem_rd_en = 1'b1; addr_rd = addr; end
            1: begin mem_wr_en = 1'b1; addr_wr = addr; wdata = wd; strb = st; end
            default: begin instr_rd_en = 1'b1; pc = addr; end
        endcase
        cycles = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sel == 0) stall = (kind == 2) ? stall_if1 : stall_mem1;
            else          stall = (kind == 2) ? stall_if4 : stall_mem4;
            if (stall) begin
                cycles++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) cycles = -1;
        if (sel == 0) rdata = (kind == 2) ? {32'd0, instr1} : data1;
        else          rdata = (kind == 2) ? {32'd0, instr4} : data4;
        @(posedge clk); #1;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        instr_rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst4 = 1'b1;
        mem_rd_en = 1'b1; instr_rd_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (stall_mem1 !== 1'b1) begin errors++;
            $display("FAIL reset_stall_mem_req got %b exp 1", stall_mem1); end
        checks++; if (stall_if1 !== 1'b1) begin errors++;
            $display("FAIL reset_stall_if_req got %b exp 1", stall_if1); end
        checks++; if (data1 !== 64'd0) begin errors++;
            $display("FAIL reset_data got %h exp 0", data1); end
        checks++; if (instr1 !== 32'd0) begin errors++;
            $display("FAIL reset_instr got %h exp 0", instr1); end
        mem_rd_en = 1'b0; instr_rd_en = 1'b0;
        @(negedge clk);
        checks++; if (stall_mem1 !== 1'b0 || stall_if1 !== 1'b0) begin errors++;
            $display("FAIL reset_stall_idle got %b%b exp 00", stall_mem1, stall_if1); end
        @(posedge clk); #1;
        rst = 1'b0; rst4 = 1'b0;
    endtask

    task automatic test_back_to_back;
        int seq[20];
        int n;
        @(posedge clk); #1;
        mem_rd_en = 1'b1; addr_rd = 64'h40;
        instr_rd_en = 1'b1; pc = 64'h100;
        n = 0;
        for (int c = 0; c < 100 && n < 20; c++) begin
            @(negedge clk);
            if (!stall_if1 && stall_mem1) begin seq[n] = 1; n++; end
            else if (!stall_mem1 && stall_if1) begin seq[n] = 0; n++; end
            else if (!stall_mem1 && !stall_if1) begin seq[n] = 2; n++; end
        end
        @(posedge clk); #1;
        mem_rd_en = 1'b0; instr_rd_en = 1'b0;
        checks++; if (n !== 20) begin errors++;
            $display("FAIL b2b_serve_count got %0d exp 20", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (seq[k] !== ((k % 2 == 0) ? 1 : 0)) begin errors++;
                $display("FAIL b2b_order[%0d] got %0d exp %0d", k, seq[k],
                         (k % 2 == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_basic;
        int          cyc;
        logic [63:0] rd;
        do_access(0, 1, 64'h40, 64'h1122334455667788, 8'hFF, cyc, rd);
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL wr_full_latency got %0d exp 2", cyc); end
        do_access(0, 0, 64'h40, 64'd0, 8'd0, cyc, rd);
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL rd_latency got %0d exp 2", cyc); end
        checks++; if (rd !== 64'h1122334455667788) begin errors++;
            $display("FAIL rd_full got %h exp 1122334455667788", rd); end
        do_access(0, 1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, cyc, rd);
        do_access(0, 0, 64'h40, 64'd0, 8'd0, cyc, rd);
        checks++; if (rd !== 64'h11223344AAAAAAAA) begin errors++;
            $display("FAIL rd_strb_merge got %h exp 11223344aaaaaaaa", rd); end
        do_access(0, 1, 64'h40, 64'h5555555555555555, 8'h00, cyc, rd);
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL wr_strb0_latency got %0d exp 2", cyc); end
        do_access(0, 0, 64'h40, 64'd0, 8'd0, cyc, rd);
        checks++; if (rd !== 64'h11223344AAAAAAAA) begin errors++;
            $display("FAIL rd_after_strb0 got %h exp 11223344aaaaaaaa", rd); end
    endtask

    task automatic test_fetch;
        int          cyc;
        logic [63:0] rd;
        do_access(0, 1, 64'h100, 64'hDEADBEEF00000013, 8'hFF, cyc, rd);
        do_access(0, 2, 64'h104, 64'd0, 8'd0, cyc, rd);
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL fetch_latency got %0d exp 2", cyc); end
        checks++; if (rd[31:0] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL fetch_hi got %h exp deadbeef", rd[31:0]); end
        do_access(0, 2, 64'h100, 64'd0, 8'd0, cyc, rd);
        checks++; if (rd[31:0] !== 32'h00000013) begin errors++;
            $display("FAIL fetch_lo got %h exp 00000013", rd[31:0]); end
        checks++; if (data1 !== 64'h11223344AAAAAAAA) begin errors++;
            $display("FAIL data_hold got %h exp 11223344aaaaaaaa", data1); end
    endtask

    task automatic test_wrap;
        int          cyc;
        logic [63:0] rd;
        do_access(0, 1, 64'h8040, 64'h0123456789ABCDEF, 8'hFF, cyc, rd);
        do_access(0, 0, 64'h0040, 64'd0, 8'd0, cyc, rd);
        checks++; if (rd !== 64'h0123456789ABCDEF) begin errors++;
            $display("FAIL wrap got %h exp 0123456789abcdef", rd); end
    endtask

    task automatic test_flush;
        int          cyc;
        logic [63:0] rd;
        do_access(0, 1, 64'h208, 64'hC0FFEE00C0FFEE00, 8'hFF, cyc, rd);
        // Write to 0x200 dropped after grant, with address/data changed while busy.
        @(posedge clk); #1;
        mem_wr_en = 1'b1; addr_wr = 64'h200; wdata = 64'h0BADF00D12345678; strb = 8'hFF;
        @(posedge clk); #1;
        mem_wr_en = 1'b0; addr_wr = 64'h208; wdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        checks++; if (stall_mem1 !== 1'b0) begin errors++;
            $display("FAIL flush_no_stall got %b exp 0", stall_mem1); end
        repeat (3) @(posedge clk);
        do_access(0, 0, 64'h200, 64'd0, 8'd0, cyc, rd);
        checks++; if (rd !== 64'h0BADF00D12345678) begin errors++;
            $display("FAIL flush_wr_commit got %h exp 0badf00d12345678", rd); end
        // Flushed read of 0x208 must still update data_mem_o.
        @(posedge clk); #1;
        mem_rd_en = 1'b1; addr_rd = 64'h208;
        @(posedge clk); #1;
        mem_rd_en = 1'b0; addr_rd = 64'h200;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (data1 !== 64'hC0FFEE00C0FFEE00) begin errors++;
            $display("FAIL flush_rd_update got %h exp c0ffee00c0ffee00", data1); end
    endtask

    task automatic test_reset_abort;
        int          cyc;
        logic [63:0] rd;
        repeat (20) @(posedge clk);
        do_access(1, 1, 64'h80, 64'h0102030405060708, 8'hFF, cyc, rd);
        checks++; if (cyc !== 5) begin errors++;
            $display("FAIL lat4_wr_latency got %0d exp 5", cyc); end
        @(posedge clk); #1;
        mem_wr_en = 1'b1; addr_wr = 64'h80; wdata = 64'hFEDCBA9876543210; strb = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst4 = 1'b1; mem_wr_en = 1'b0;
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(negedge clk);
        checks++; if (data4 !== 64'd0) begin errors++;
            $display("FAIL lat4_reset_data got %h exp 0", data4); end
        do_access(1, 0, 64'h80, 64'd0, 8'd0, cyc, rd);
        checks++; if (cyc !== 5) begin errors++;
            $display("FAIL lat4_rd_latency got %0d exp 5", cyc); end
        checks++; if (rd !== 64'h0102030405060708) begin errors++;
            $display("FAIL lat4_abort got %h exp 0102030405060708", rd); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_basic();
        test_fetch();
        test_wrap();
        test_flush();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
